// File: rtl/lsu_data_mem_responder.sv
// lsu_data_mem_responder: behavioural LSU data memory with grant stalls, in-order latency queue and error injection
module lsu_data_mem_responder #(
   parameter int unsigned MEM_WORDS = 1024,
   parameter logic [31:0] ADDR_BASE = 32'h0000_0000,
   parameter int unsigned MAX_OUTST = 2
) (
   input  logic        clk_i,
   input  logic        rst_i,
   input  logic        data_req_i,
   input  logic [31:0] data_addr_i,
   input  logic        data_we_i,
   input  logic [3:0]  data_be_i,
   input  logic [31:0] data_wdata_i,
   output logic        data_gnt_o,
   output logic        data_rvalid_o,
   output logic [31:0] data_rdata_o,
   output logic        data_err_o,
   input  logic [3:0]  cfg_gnt_stall_i,
   input  logic [3:0]  cfg_rsp_lat_i,
   input  logic        cfg_err_en_i,
   input  logic [31:0] cfg_err_addr_i,
   input  logic        bd_we_i,
   input  logic [31:0] bd_addr_i,
   input  logic [31:0] bd_wdata_i,
   output logic [15:0] req_cnt_o,
   output logic        proto_err_o
);
   localparam int AW = MEM_WORDS > 1 ? $clog2(MEM_WORDS) : 1;
   typedef enum logic {IDLE, STALL} state_t;
   typedef struct packed {
      logic [31:0] rdata;
      logic        err;
      logic [3:0]  cnt;
   } entry_t;
   state_t      state, state_n;
   logic [3:0]  stall_cnt, stall_cnt_n;
   logic [31:0] hold_addr, hold_wdata;
   logic [3:0]  hold_be;
   logic        hold_we, proto_set, changed;
   entry_t      q [MAX_OUTST];
   entry_t      q_n [MAX_OUTST];
   entry_t      push_e;
   logic [2:0]  q_cnt, q_cnt_n;
   logic [31:0] mem [MEM_WORDS];
   logic [31:0] req_woff, bd_woff;
   logic        req_err, full, rv_n;
   assign req_woff = (data_addr_i - ADDR_BASE) >> 2;
   assign bd_woff = (bd_addr_i - ADDR_BASE) >> 2;
   assign req_err = req_woff >= MEM_WORDS || (cfg_err_en_i && ((data_addr_i ^ cfg_err_addr_i) >> 2) == 32'h0);
   assign full = q_cnt == 3'(MAX_OUTST);
   assign changed = data_addr_i != hold_addr || data_we_i != hold_we || data_be_i != hold_be || data_wdata_i != hold_wdata;
   assign push_e = {(data_we_i || req_err) ? 32'h0 : mem[req_woff[AW-1:0]], req_err, cfg_rsp_lat_i};
   assign rv_n = q_cnt_n != 3'd0 && q_n[0].cnt == 4'd0;
   always_comb begin
      state_n = state;
      stall_cnt_n = stall_cnt;
      data_gnt_o = 1'b0;
      proto_set = 1'b0;
      if (state == IDLE) begin
         if (data_req_i && !full) begin
            if (cfg_gnt_stall_i == 4'd0) data_gnt_o = 1'b1;
            else begin
               stall_cnt_n = cfg_gnt_stall_i - 4'd1;
               state_n = STALL;
            end
         end
      end else if (!data_req_i) begin
         proto_set = 1'b1;
         state_n = IDLE;
      end else begin
         proto_set = changed;
         if (stall_cnt != 4'd0) stall_cnt_n = stall_cnt - 4'd1;
         else if (!full) begin
            data_gnt_o = 1'b1;
            state_n = IDLE;
         end
      end
      if (rst_i) data_gnt_o = 1'b0;
   end
   always_comb begin
      q_n = q;
      q_cnt_n = q_cnt - 3'(data_rvalid_o);
      if (data_rvalid_o)
         for (int i = 0; i < int'(MAX_OUTST) - 1; i++) q_n[i] = q[i + 1];
      for (int i = 0; i < int'(MAX_OUTST); i++) begin
         q_n[i].cnt = q_n[i].cnt == 4'd0 ? 4'd0 : q_n[i].cnt - 4'd1;
         if (data_gnt_o && q_cnt_n == 3'(i)) q_n[i] = push_e;
      end
      if (data_gnt_o) q_cnt_n = q_cnt_n + 3'd1;
   end
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state <= IDLE;
         stall_cnt <= 4'd0;
         q_cnt <= 3'd0;
         data_rvalid_o <= 1'b0;
         data_rdata_o <= 32'h0;
         data_err_o <= 1'b0;
         req_cnt_o <= 16'h0;
         proto_err_o <= 1'b0;
      end else begin
         state <= state_n;
         stall_cnt <= stall_cnt_n;
         q <= q_n;
         q_cnt <= q_cnt_n;
         data_rvalid_o <= rv_n;
         data_rdata_o <= rv_n ? q_n[0].rdata : 32'h0;
         data_err_o <= rv_n && q_n[0].err;
         req_cnt_o <= req_cnt_o + 16'(data_gnt_o);
         proto_err_o <= proto_err_o | proto_set;
      end
   end
   always_ff @(posedge clk_i) begin
      if (state == IDLE) begin
         hold_addr <= data_addr_i;
         hold_we <= data_we_i;
         hold_be <= data_be_i;
         hold_wdata <= data_wdata_i;
      end
      if (bd_we_i && bd_woff < MEM_WORDS) mem[bd_woff[AW-1:0]] <= bd_wdata_i;
      for (int b = 0; b < 4; b++)
         if (data_gnt_o && data_we_i && !req_err && data_be_i[b])
            mem[req_woff[AW-1:0]][8*b +: 8] <= data_wdata_i[8*b +: 8];
   end
endmodule

// File: tb/tb_lsu_data_mem_responder.sv
// tb_lsu_data_mem_responder: directed plus randomized checks against a cycle-level response model
module tb_lsu_data_mem_responder;
   localparam int MEM_WORDS = 1024;
   localparam int MAX_OUTST = 2;
   localparam logic [31:0] ADDR_BASE = 32'h0;
   typedef struct {
      int          g;
      int          rv;
      logic [31:0] rdata;
      logic        err;
   } rsp_t;
   logic        clk_i = 1'b0, rst_i = 1'b1;
   logic        data_req, data_we, data_gnt, data_rvalid, data_err;
   logic [31:0] data_addr, data_wdata, data_rdata;
   logic [3:0]  data_be, cfg_gnt_stall, cfg_rsp_lat;
   logic        cfg_err_en, bd_we, proto_err;
   logic [31:0] cfg_err_addr, bd_addr, bd_wdata;
   logic [15:0] req_cnt;
   rsp_t        exp_q[$];
   logic [31:0] ref_mem [MEM_WORDS];
   int          cyc = 0, checks = 0, errors = 0, n_gnt = 0, last_rv = 0;
   logic [31:0] last_rdata = 32'h0;
   logic        last_err = 1'b0, mon_v;

   lsu_data_mem_responder #(.MEM_WORDS(MEM_WORDS), .ADDR_BASE(ADDR_BASE), .MAX_OUTST(MAX_OUTST)) dut (
      .clk_i(clk_i), .rst_i(rst_i),
      .data_req_i(data_req), .data_addr_i(data_addr), .data_we_i(data_we), .data_be_i(data_be),
      .data_wdata_i(data_wdata), .data_gnt_o(data_gnt), .data_rvalid_o(data_rvalid),
      .data_rdata_o(data_rdata), .data_err_o(data_err),
      .cfg_gnt_stall_i(cfg_gnt_stall), .cfg_rsp_lat_i(cfg_rsp_lat), .cfg_err_en_i(cfg_err_en),
      .cfg_err_addr_i(cfg_err_addr), .bd_we_i(bd_we), .bd_addr_i(bd_addr), .bd_wdata_i(bd_wdata),
      .req_cnt_o(req_cnt), .proto_err_o(proto_err)
   );

   always #5 clk_i = ~clk_i;
   always @(posedge clk_i) cyc <= cyc + 1;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s cyc=%0d got=%h exp=%h", tag, cyc, got, exp);
      end
   endtask

   task automatic fail(input string tag);
      checks++;
      errors++;
      $error("FAIL %s bound expired cyc=%0d", tag, cyc);
   endtask

   task automatic tick();
      @(posedge clk_i);
      #1;
   endtask

   function automatic int occ(input int c);
      int n = 0;
      foreach (exp_q[i]) if (exp_q[i].g < c && c <= exp_q[i].rv) n++;
      return n;
   endfunction

   function automatic int exp_gnt(input int r, input int s);
      int c = r;
      while (occ(c) >= MAX_OUTST) c++;
      if (s != 0) begin
         c += s;
         while (occ(c) >= MAX_OUTST) c++;
      end
      return c;
   endfunction

   task automatic bd_write(input logic [31:0] a, input logic [31:0] d);
      logic [31:0] w;
      w = (a - ADDR_BASE) >> 2;
      bd_we = 1'b1; bd_addr = a; bd_wdata = d;
      if (w < MEM_WORDS) ref_mem[w] = d;
      tick();
      bd_we = 1'b0;
   endtask

   task automatic do_req(input logic [31:0] a, input logic we, input logic [3:0] be, input logic [31:0] wd, output int g);
      int r, eg, rv;
      bit done;
      logic e;
      logic [31:0] w, rd;
      data_req = 1'b1; data_addr = a; data_we = we; data_be = be; data_wdata = wd;
      r = cyc;
      eg = exp_gnt(r, int'(cfg_gnt_stall));
      done = 1'b0;
      g = -1;
      while (!done) begin
         @(negedge clk_i);
         chk("gnt", data_gnt, cyc == eg);
         if (data_gnt) begin
            done = 1'b1;
            g = cyc;
         end else if (cyc >= eg + 8) begin
            fail("gnt_wait");
            done = 1'b1;
         end
      end
      if (g >= 0) begin
         w = (a - ADDR_BASE) >> 2;
         e = w >= MEM_WORDS || (cfg_err_en && a[31:2] == cfg_err_addr[31:2]);
         rd = (we || e) ? 32'h0 : ref_mem[w];
         if (we && !e)
            for (int b = 0; b < 4; b++) if (be[b]) ref_mem[w][8*b +: 8] = wd[8*b +: 8];
         rv = g + 1 + int'(cfg_rsp_lat);
         if (rv <= last_rv) rv = last_rv + 1;
         last_rv = rv;
         n_gnt++;
         exp_q.push_back('{g: g, rv: rv, rdata: rd, err: e});
      end
      tick();
      data_req = 1'b0;
      bd_we = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 200) begin
         tick();
         n++;
      end
      if (exp_q.size() != 0) begin
         fail("drain");
         exp_q.delete();
      end
      tick();
   endtask

   always @(negedge clk_i) if (!rst_i) begin
      mon_v = exp_q.size() != 0 && exp_q[0].rv == cyc;
      chk("rvalid", data_rvalid, mon_v);
      if (mon_v) begin
         chk("rdata", data_rdata, exp_q[0].rdata);
         chk("err", data_err, exp_q[0].err);
         last_rdata = data_rdata;
         last_err = data_err;
         void'(exp_q.pop_front());
      end else begin
         chk("idle_rdata", data_rdata, 32'h0);
         chk("idle_err", data_err, 1'b0);
         if (exp_q.size() != 0 && exp_q[0].rv < cyc) void'(exp_q.pop_front());
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog cyc=%0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int g, g1, g3;
      logic [31:0] a;
      data_req = 1'b0; data_addr = 32'h0; data_we = 1'b0; data_be = 4'h0; data_wdata = 32'h0;
      cfg_gnt_stall = 4'd0; cfg_rsp_lat = 4'd0; cfg_err_en = 1'b0; cfg_err_addr = 32'h0;
      bd_we = 1'b0; bd_addr = 32'h0; bd_wdata = 32'h0;
      repeat (2) tick();
      chk("rst_gnt", data_gnt, 1'b0);
      chk("rst_rvalid", data_rvalid, 1'b0);
      chk("rst_rdata", data_rdata, 32'h0);
      chk("rst_err", data_err, 1'b0);
      chk("rst_req_cnt", req_cnt, 16'h0);
      chk("rst_proto", proto_err, 1'b0);
      rst_i = 1'b0;
      for (int i = 0; i < MEM_WORDS; i++) bd_write(ADDR_BASE + 32'(i * 4), $urandom);

      do_req(32'h10, 1'b1, 4'hF, 32'hA5A5_1234, g);
      do_req(32'h10, 1'b0, 4'hF, 32'h0, g);
      chk("req_cnt_2", req_cnt, 16'd2);
      drain();
      chk("wr_rd_0x10", last_rdata, 32'hA5A5_1234);

      bd_write(32'h20, 32'h1122_3344);
      do_req(32'h20, 1'b1, 4'b0010, 32'h0000_AB00, g);
      do_req(32'h20, 1'b0, 4'hF, 32'h0, g);
      drain();
      chk("bd_merge", last_rdata, 32'h1122_AB44);

      cfg_gnt_stall = 4'd3; cfg_rsp_lat = 4'd2;
      do_req(32'h20, 1'b0, 4'hF, 32'h0, g);
      drain();
      chk("stall_rd", last_rdata, 32'h1122_AB44);
      chk("proto_clean", proto_err, 1'b0);
      data_req = 1'b1; data_addr = 32'h24; data_we = 1'b0; data_be = 4'hF; data_wdata = 32'h0;
      @(negedge clk_i);
      chk("stall_gnt0", data_gnt, 1'b0);
      tick();
      data_req = 1'b0;
      repeat (2) tick();
      chk("proto_set", proto_err, 1'b1);
      do_req(32'h24, 1'b0, 4'hF, 32'h0, g);
      drain();
      chk("proto_sticky", proto_err, 1'b1);

      cfg_gnt_stall = 4'd0; cfg_rsp_lat = 4'd5;
      do_req(32'h10, 1'b0, 4'hF, 32'h0, g1);
      do_req(32'h14, 1'b0, 4'hF, 32'h0, g);
      do_req(32'h20, 1'b0, 4'hF, 32'h0, g3);
      chk("full_gnt_gap", 32'(g3 - g1), 32'd7);
      drain();

      cfg_rsp_lat = 4'd1;
      bd_write(32'h40, 32'h55AA_55AA);
      cfg_err_en = 1'b1; cfg_err_addr = 32'h40;
      do_req(32'h40, 1'b1, 4'hF, 32'h4433_2211, g);
      do_req(32'h40, 1'b0, 4'hF, 32'h0, g);
      drain();
      chk("errrd_err", last_err, 1'b1);
      chk("errrd_data", last_rdata, 32'h0);
      do_req(ADDR_BASE + 32'(4 * MEM_WORDS), 1'b0, 4'hF, 32'h0, g);
      drain();
      chk("oob_err", last_err, 1'b1);
      cfg_err_en = 1'b0;
      do_req(32'h40, 1'b0, 4'hF, 32'h0, g);
      drain();
      chk("err_mem_kept", last_rdata, 32'h55AA_55AA);

      bd_write(ADDR_BASE + 32'(4 * MEM_WORDS), 32'hDEAD_BEEF);
      do_req(32'h0, 1'b0, 4'hF, 32'h0, g);
      drain();

      cfg_rsp_lat = 4'd0;
      bd_we = 1'b1; bd_addr = 32'h30; bd_wdata = 32'hCAFE_F00D; ref_mem[12] = 32'hCAFE_F00D;
      do_req(32'h30, 1'b1, 4'b0101, 32'h1122_3344, g);
      do_req(32'h30, 1'b0, 4'hF, 32'h0, g);
      drain();
      chk("collide", last_rdata, 32'hCA22_F044);

      cfg_rsp_lat = 4'd8;
      do_req(32'h10, 1'b0, 4'hF, 32'h0, g);
      do_req(32'h14, 1'b0, 4'hF, 32'h0, g);
      rst_i = 1'b1;
      exp_q.delete();
      n_gnt = 0;
      last_rv = 0;
      tick();
      rst_i = 1'b0;
      chk("mid_rst_req_cnt", req_cnt, 16'h0);
      chk("mid_rst_proto", proto_err, 1'b0);
      repeat (12) tick();
      cfg_rsp_lat = 4'd0;
      do_req(32'h10, 1'b0, 4'hF, 32'h0, g);
      drain();
      chk("rst_mem_kept", last_rdata, 32'hA5A5_1234);

      for (int n = 0; n < 80; n++) begin
         cfg_gnt_stall = 4'($urandom_range(0, 3));
         cfg_rsp_lat = 4'($urandom_range(0, 5));
         cfg_err_en = $urandom_range(0, 3) == 0;
         cfg_err_addr = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
         if ($urandom_range(0, 7) == 0) a = $urandom_range(0, 1) != 0 ? 32'h1000 + 32'($urandom_range(0, 15) * 4) : 32'hFFFF_FFFC;
         else a = {24'h0, 6'($urandom_range(0, 63)), 2'($urandom)};
         do_req(a, 1'($urandom), 4'($urandom), $urandom, g);
         if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) tick();
      end
      drain();
      chk("rand_req_cnt", req_cnt, 16'(n_gnt));
      chk("rand_proto", proto_err, 1'b0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/lsu_data_mem_responder.md
Name: lsu_data_mem_responder

Overview:
- Behavioural data-side memory and responder that drives the LSU data bus inputs (gnt, rvalid, rdata, err) in the LSU unit-test bench.
- Sits directly upstream of the LSU read-data path: consumes data_req/addr/we/be/wdata and produces the responses the LSU and its monitor observe.
- Provides programmable grant stalls, response latency, in-order pipelined responses and error injection for directed LSU tests.

Parameters:
- MEM_WORDS, 1024, number of 32-bit words in the memory (power of 2).
- ADDR_BASE, 32'h0000_0000, byte address of word 0. Must be word-aligned.
- MAX_OUTST, 2, depth of the response queue (outstanding granted requests), 1..4.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- data_req_i  in  1  LSU request
- data_addr_i  in  32  byte address (bits [1:0] ignored)
- data_we_i  in  1  1=write, 0=read
- data_be_i  in  4  byte enables
- data_wdata_i  in  32  write data
- data_gnt_o  out  1  grant
- data_rvalid_o  out  1  response valid (exactly one cycle per granted request)
- data_rdata_o  out  32  read data
- data_err_o  out  1  bus error with rvalid
- cfg_gnt_stall_i  in  4  cycles gnt is held low after a new request is seen
- cfg_rsp_lat_i  in  4  additional response delay cycles
- cfg_err_en_i  in  1  enable address-match error injection
- cfg_err_addr_i  in  32  word address (bits [1:0] ignored) that returns an error
- bd_we_i  in  1  backdoor word write
- bd_addr_i  in  32  backdoor byte address
- bd_wdata_i  in  32  backdoor data
- req_cnt_o  out  16  granted-request count, wraps at 16'hFFFF->0
- proto_err_o  out  1  sticky protocol-violation flag

Behaviour:
- Reset (rst_i high at clk_i edge): gnt, rvalid, err, proto_err_o=0; rdata=0; req_cnt_o=0; queue emptied; FSM->IDLE. Memory contents are NOT reset. Reset mid-transaction drops all pending responses.
- FSM IDLE: req high, queue not full -> if cfg_gnt_stall_i==0, gnt=1 combinationally this cycle; else load stall counter with cfg_gnt_stall_i and go STALL with gnt=0.
- FSM STALL: decrement each cycle; gnt=1 in the cycle the counter reaches 0 (i.e. cfg_gnt_stall_i cycles of gnt=0 before the gnt cycle), then IDLE. A queue-full condition in that cycle holds gnt low until space is available.
- STALL: req dropping or addr/we/be/wdata changing before gnt -> proto_err_o=1 (sticky); req drop also returns FSM to IDLE.
- Queue full (MAX_OUTST entries): gnt=0. A pop in the same cycle does not free a slot until the next cycle.
- Grant cycle actions: req_cnt_o increments; entry pushed with countdown=cfg_rsp_lat_i. Error status is computed here.
- Error condition: word address outside [ADDR_BASE, ADDR_BASE+4*MEM_WORDS), or cfg_err_en_i and addr[31:2]==cfg_err_addr_i[31:2].
- Error writes do not modify memory. Error reads return rdata=0, err=1.
- Write: bytes with data_be_i set are updated at the grant edge. Entry rdata=0, err=0 unless the error condition holds.
- Read: entry rdata is the memory word sampled at grant (full word, be ignored), with that cycle's write not yet applied.
- Responses: every entry's countdown decrements each cycle, saturating at 0.
- Head pops when its countdown==0 and it was pushed at least one cycle earlier. rvalid, rdata and err are registered, so rvalid follows gnt by 1+cfg_rsp_lat_i cycles minimum.
- Strict in-order: a younger entry that expires first waits behind the head. At most one rvalid per cycle.
- rdata=0 and err=0 whenever rvalid=0.
- Back-to-back: with stall=0 and lat=0, gnt may be high every cycle with rvalid following each one a cycle later; throughput is 1/cycle.
- Backdoor: bd_we_i writes the full word at the clock edge, with no grant or response. Same-cycle collision with a bus write to the same word: the bus write wins for enabled bytes, backdoor for the rest. Out-of-range backdoor addresses are ignored.

Test Plan:
- stall=0, lat=0: write 0xA5A5_1234 to 0x10 (be=1111), then read 0x10 -> gnt same cycle as req; rvalid 1 cycle after each gnt; read rdata=0xA5A5_1234, err=0; req_cnt_o=2.
- Backdoor 0x20=0x1122_3344, bus write 0x20 be=0010 wdata=0x0000_AB00, read 0x20 -> rdata=0x1122_AB44.
- stall=3, lat=2, read 0x20 -> 3 cycles gnt=0, gnt on 4th cycle, rvalid 3 cycles after gnt; drop req during stall in a second request -> proto_err_o=1 and stays 1 until reset.
- MAX_OUTST=2, lat=5, three back-to-back reads -> gnt for the first two only, third granted the cycle after the first rvalid; responses in order.
- cfg_err_en_i=1, cfg_err_addr_i=0x40, write 0x44332211 to 0x40 then read 0x40, and read ADDR_BASE+4*MEM_WORDS -> both responses err=1, rdata=0; memory at 0x40 unchanged (backdoor-preloaded value readable after cfg_err_en_i=0).
- Assert rst_i with two responses pending -> no rvalid afterwards, req_cnt_o=0, memory contents retained.
